// File: rtl/game_pkg.sv
// Shared types and defaults for the 2048 board controller and its line merger.
// Latency: n/a (types, constants and a pure LFSR step function only).
// Backpressure: n/a.
package game_pkg;

    typedef logic [11:0] tile_t;
    typedef tile_t [3:0] line_t;
    typedef line_t [3:0] board_t;   // board[r][c], r=0 top row, c=0 left column

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_SPAWN_A,
        S_SPAWN_B,
        S_WAIT,
        S_MOVE,
        S_SPAWN,
        S_CHECK,
        S_DONE
    } ctrl_state_t;

    localparam tile_t       WIN_VAL_DEF   = 12'd2048;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    // Fibonacci LFSR step, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/move_ctrl_if.sv
// Control/board bundle between the 2048 sequencer and its driver.
// Latency: n/a (wiring only).
// Backpressure: move_valid is honoured only while move_ready is high.
interface move_ctrl_if;
    import game_pkg::*;

    logic        start;
    logic        load;
    board_t      load_board;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic        move_ready;
    board_t      board;
    logic        busy;
    logic        moved;
    logic [12:0] gain;
    logic        win;
    logic        lose;

    modport master (
        output start, load, load_board, move_valid, move_dir,
        input  move_ready, board, busy, moved, gain, win, lose
    );

    modport slave (
        input  start, load, load_board, move_valid, move_dir,
        output move_ready, board, busy, moved, gain, win, lose
    );

endinterface

// File: rtl/line_merge.sv
// Slides one 4-cell line toward index 0 and merges equal neighbours once each.
// Latency: purely combinational.
// Backpressure: none.
module line_merge
    import game_pkg::*;
(
    input  line_t       line_i,
    output line_t       line_o,
    output logic        changed_o,
    output logic [12:0] gain_o
);

    // Compact nonzero tiles, then pair-merge scanning from index 0.
    always_comb begin
        tile_t      comp [5];   // extra zero slot so comp[i+1] is always valid
        logic [2:0] n;
        logic [2:0] j;
        logic       skip;

        for (int i = 0; i < 5; i++) comp[i] = '0;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (line_i[i] != '0) begin
                comp[n] = line_i[i];
                n       = n + 3'd1;
            end
        end

        line_o = '0;
        gain_o = '0;
        j      = 3'd0;
        skip   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (comp[i] != '0) begin
                if (comp[i] == comp[i+1]) begin
                    line_o[j[1:0]] = {comp[i][10:0], 1'b0};
                    gain_o         = gain_o + {comp[i], 1'b0};
                    skip           = 1'b1;
                end else begin
                    line_o[j[1:0]] = comp[i];
                end
                j = j + 3'd1;
            end
        end

        changed_o = (line_o != line_i);
    end

endmodule

// File: rtl/move_ctrl.sv
// 2048 sequencer: owns the 4x4 board, slides/merges one line per cycle, spawns, checks win/lose. Option: SPAWN_FOUR_EN.
// Latency: accept->ready 6 cycles when the board changes, 4 when not; start->ready 4 cycles.
// Backpressure: move_ready only in WAIT; move_valid elsewhere is dropped, never queued.
module move_ctrl
    import game_pkg::*;
#(
    parameter tile_t       WIN_VAL   = WIN_VAL_DEF,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic          clk,
    input  logic          rst,
    move_ctrl_if.slave    bus
);

    ctrl_state_t  state_q;
    board_t       board_q;
    logic [15:0]  lfsr_q;
    dir_t         dir_q;
    logic [1:0]   k_q;
    logic         changed_q;
    logic [12:0]  gain_q;
    logic         moved_q;
    logic         win_q;
    logic         lose_q;

    logic [3:0][1:0] ln_r;
    logic [3:0][1:0] ln_c;
    line_t        line_in;
    line_t        line_out;
    logic         ln_changed;
    logic [12:0]  ln_gain;
    board_t       mv_board_d;
    board_t       sp_board_d;
    tile_t        spawn_val;
    logic         any_win;
    logic         any_empty;
    logic         any_pair;

`ifdef SPAWN_FOUR_EN
    assign spawn_val = (lfsr_q[7:4] == 4'd0) ? 12'd4 : 12'd2;
`else
    assign spawn_val = 12'd2;
`endif

    // Map line position i of line k to board coordinates, ordered toward the slide direction.
    always_comb begin
        ln_r    = '0;
        ln_c    = '0;
        line_in = '0;
        for (int i = 0; i < 4; i++) begin
            case (dir_q)
                DIR_LEFT:  begin ln_r[i] = k_q;        ln_c[i] = 2'(i);     end
                DIR_RIGHT: begin ln_r[i] = k_q;        ln_c[i] = 2'(3 - i); end
                DIR_UP:    begin ln_r[i] = 2'(i);      ln_c[i] = k_q;       end
                default:   begin ln_r[i] = 2'(3 - i);  ln_c[i] = k_q;       end
            endcase
            line_in[i] = board_q[ln_r[i]][ln_c[i]];
        end
    end

    line_merge u_merge (
        .line_i    (line_in),
        .line_o    (line_out),
        .changed_o (ln_changed),
        .gain_o    (ln_gain)
    );

    // Board with the merged line written back in place.
    always_comb begin
        mv_board_d = board_q;
        for (int i = 0; i < 4; i++) begin
            mv_board_d[ln_r[i]][ln_c[i]] = line_out[i];
        end
    end

    // Spawn: first empty cell scanning linearly from the LFSR start index, wrapping at 16.
    always_comb begin
        logic [3:0] idx;
        logic       found;
        sp_board_d = board_q;
        found      = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = lfsr_q[3:0] + 4'(i);
            if (!found && board_q[idx[3:2]][idx[1:0]] == '0) begin
                found = 1'b1;
                sp_board_d[idx[3:2]][idx[1:0]] = spawn_val;
            end
        end
    end

    // End-of-game scan: winning tile, any empty cell, any adjacent equal pair.
    always_comb begin
        any_win   = 1'b0;
        any_empty = 1'b0;
        any_pair  = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (board_q[r][c] == WIN_VAL) any_win   = 1'b1;
                if (board_q[r][c] == '0)      any_empty = 1'b1;
            end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (board_q[r][c] == board_q[r][c+1]) any_pair = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                if (board_q[r][c] == board_q[r+1][c]) any_pair = 1'b1;
    end

    // Sequencer FSM; start beats load, load only lands from IDLE/WAIT/DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            board_q   <= '0;
            lfsr_q    <= LFSR_SEED;
            dir_q     <= DIR_LEFT;
            k_q       <= 2'd0;
            changed_q <= 1'b0;
            gain_q    <= '0;
            moved_q   <= 1'b0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_next(lfsr_q);
            moved_q <= 1'b0;
            if (bus.start) begin
                state_q <= S_INIT;
                board_q <= '0;
                win_q   <= 1'b0;
                lose_q  <= 1'b0;
                gain_q  <= '0;
            end else if (bus.load &&
                         (state_q == S_IDLE || state_q == S_WAIT || state_q == S_DONE)) begin
                board_q <= bus.load_board;
                win_q   <= 1'b0;
                lose_q  <= 1'b0;
                state_q <= S_CHECK;
            end else begin
                case (state_q)
                    S_INIT: begin
                        board_q <= '0;
                        win_q   <= 1'b0;
                        lose_q  <= 1'b0;
                        gain_q  <= '0;
                        state_q <= S_SPAWN_A;
                    end
                    S_SPAWN_A: begin
                        board_q <= sp_board_d;
                        state_q <= S_SPAWN_B;
                    end
                    S_SPAWN_B: begin
                        board_q <= sp_board_d;
                        state_q <= S_CHECK;
                    end
                    S_WAIT: begin
                        if (bus.move_valid) begin
                            dir_q     <= dir_t'(bus.move_dir);
                            k_q       <= 2'd0;
                            changed_q <= 1'b0;
                            gain_q    <= '0;
                            state_q   <= S_MOVE;
                        end
                    end
                    S_MOVE: begin
                        board_q   <= mv_board_d;
                        changed_q <= changed_q | ln_changed;
                        gain_q    <= gain_q + ln_gain;
                        k_q       <= k_q + 2'd1;
                        if (k_q == 2'd3)
                            state_q <= (changed_q | ln_changed) ? S_SPAWN : S_WAIT;
                    end
                    S_SPAWN: begin
                        board_q <= sp_board_d;
                        moved_q <= 1'b1;   // visible during the CHECK cycle
                        state_q <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (any_win) begin
                            win_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else if (!any_empty && !any_pair) begin
                            lose_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                    default: state_q <= state_q;   // IDLE and DONE hold
                endcase
            end
        end
    end

    assign bus.board      = board_q;
    assign bus.move_ready = (state_q == S_WAIT);
    assign bus.busy       = (state_q == S_INIT)    || (state_q == S_SPAWN_A) ||
                            (state_q == S_SPAWN_B) || (state_q == S_MOVE)    ||
                            (state_q == S_SPAWN)   || (state_q == S_CHECK);
    assign bus.moved      = moved_q;
    assign bus.gain       = gain_q;
    assign bus.win        = win_q;
    assign bus.lose       = lose_q;

endmodule

// File: tb/tb_move_ctrl.sv
// Directed bench for move_ctrl with a scoreboard queue of expected results.
// Latency: n/a.
// Backpressure: moves are issued only when move_ready is observed high.
module tb_move_ctrl;
    import game_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    move_ctrl_if bus ();

    move_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb [$];
    int   total = 0;
    int   bad   = 0;
    int   moved_cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL sb_underflow observed=%0d expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    function automatic int cnt_nz(input board_t b);
        int n = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (b[r][c] !== 12'd0) n++;
        return n;
    endfunction

    function automatic int cnt_val(input board_t b, input int v);
        int n = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (b[r][c] === 12'(v)) n++;
        return n;
    endfunction

    function automatic int sum_b(input board_t b);
        int s = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s += int'(b[r][c]);
        return s;
    endfunction

    task automatic wait_ready(output int n);
        n = 0;
        moved_cnt = 0;
        while (bus.move_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (bus.moved === 1'b1) moved_cnt++;
        end
    endtask

    task automatic do_load(input board_t b);
        bus.load_board = b;
        bus.load       = 1'b1;
        tick();
        bus.load       = 1'b0;
    endtask

    task automatic do_move(input logic [1:0] d);
        bus.move_dir   = d;
        bus.move_valid = 1'b1;
        tick();
        bus.move_valid = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        board_t ld;
        board_t snap;
        int     n;

        bus.start      = 1'b0;
        bus.load       = 1'b0;
        bus.load_board = '0;
        bus.move_valid = 1'b0;
        bus.move_dir   = 2'd0;
        rst            = 1'b1;
        tick();
        tick();

        // reset state
        push("rst_board_nz", 0);  push("rst_ready", 0); push("rst_busy", 0);
        push("rst_win", 0);       push("rst_lose", 0);  push("rst_moved", 0);
        push("rst_gain", 0);
        pop_chk(cnt_nz(bus.board)); pop_chk(bus.move_ready); pop_chk(bus.busy);
        pop_chk(bus.win);           pop_chk(bus.lose);       pop_chk(bus.moved);
        pop_chk(bus.gain);
        rst = 1'b0;
        tick();

        // new game: two spawned 2s
        push("start_lat", 4); push("start_nz", 2); push("start_twos", 2); push("start_sum", 4);
        do_start();
        wait_ready(n);
        pop_chk(n); pop_chk(cnt_nz(bus.board)); pop_chk(cnt_val(bus.board, 2)); pop_chk(sum_b(bus.board));

        // LEFT on {2,2,4,4}
        ld = '0;
        ld[0][0] = 12'd2; ld[0][1] = 12'd2; ld[0][2] = 12'd4; ld[0][3] = 12'd4;
        push("load_lat", 1); push("load_eq", 1);
        do_load(ld);
        wait_ready(n);
        pop_chk(n); pop_chk(bus.board === ld);
        push("left_busy", 1); push("left_lat", 6); push("left_r0c0", 4); push("left_r0c1", 8);
        push("left_nz", 3); push("left_sum", 14); push("left_twos", 1); push("left_gain", 12);
        push("left_moved", 1);
        do_move(2'd0);
        pop_chk(bus.busy);
        wait_ready(n);
        pop_chk(n); pop_chk(bus.board[0][0]); pop_chk(bus.board[0][1]);
        pop_chk(cnt_nz(bus.board)); pop_chk(sum_b(bus.board)); pop_chk(cnt_val(bus.board, 2));
        pop_chk(bus.gain); pop_chk(moved_cnt);

        // no-change moves on packed {2,4,8,16}
        ld = '0;
        ld[0][0] = 12'd2; ld[0][1] = 12'd4; ld[0][2] = 12'd8; ld[0][3] = 12'd16;
        do_load(ld);
        wait_ready(n);
        push("nochg_l_lat", 4); push("nochg_l_eq", 1); push("nochg_l_gain", 0); push("nochg_l_moved", 0);
        do_move(2'd0);
        wait_ready(n);
        pop_chk(n); pop_chk(bus.board === ld); pop_chk(bus.gain); pop_chk(moved_cnt);
        push("nochg_r_lat", 4); push("nochg_r_eq", 1); push("nochg_r_gain", 0);
        do_move(2'd1);
        wait_ready(n);
        pop_chk(n); pop_chk(bus.board === ld); pop_chk(bus.gain);

        // UP on column 0 = {2,2,2,2}
        ld = '0;
        for (int r = 0; r < 4; r++) ld[r][0] = 12'd2;
        do_load(ld);
        wait_ready(n);
        push("up_lat", 6); push("up_r0c0", 4); push("up_r1c0", 4); push("up_gain", 8);
        push("up_nz", 3); push("up_sum", 10);
        do_move(2'd2);
        wait_ready(n);
        pop_chk(n); pop_chk(bus.board[0][0]); pop_chk(bus.board[1][0]); pop_chk(bus.gain);
        pop_chk(cnt_nz(bus.board)); pop_chk(sum_b(bus.board));

        // DOWN on column 1, bottom-up {4,4,8,0}
        ld = '0;
        ld[1][1] = 12'd8; ld[2][1] = 12'd4; ld[3][1] = 12'd4;
        do_load(ld);
        wait_ready(n);
        push("down_lat", 6); push("down_r3c1", 8); push("down_r2c1", 8); push("down_gain", 8);
        push("down_sum", 18); push("down_nz", 3);
        do_move(2'd3);
        wait_ready(n);
        pop_chk(n); pop_chk(bus.board[3][1]); pop_chk(bus.board[2][1]); pop_chk(bus.gain);
        pop_chk(sum_b(bus.board)); pop_chk(cnt_nz(bus.board));

        // win: 1024+1024 on row 3
        ld = '0;
        ld[3][0] = 12'd1024; ld[3][1] = 12'd1024;
        do_load(ld);
        wait_ready(n);
        push("win_lat", 6); push("win_tile", 2048); push("win_gain", 2048);
        push("win_ready", 0); push("win_busy", 0); push("win_lose", 0);
        do_move(2'd0);
        n = 0;
        while (bus.win !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        pop_chk(n); pop_chk(bus.board[3][0]); pop_chk(bus.gain);
        pop_chk(bus.move_ready); pop_chk(bus.busy); pop_chk(bus.lose);
        snap = bus.board;
        push("done_ignore_eq", 1); push("done_ready", 0); push("done_win", 1);
        bus.move_valid = 1'b1;
        bus.move_dir   = 2'd1;
        for (int i = 0; i < 5; i++) tick();
        bus.move_valid = 1'b0;
        pop_chk(bus.board === snap); pop_chk(bus.move_ready); pop_chk(bus.win);
        push("restart_win", 0); push("restart_nz", 2);
        do_start();
        wait_ready(n);
        pop_chk(bus.win); pop_chk(cnt_nz(bus.board));

        // lose: full checkerboard of 2/4
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                ld[r][c] = ((r + c) % 2 == 1) ? 12'd4 : 12'd2;
        push("lose_lat", 1); push("lose_win", 0); push("lose_ready", 0); push("lose_busy", 0);
        do_load(ld);
        n = 0;
        while (bus.lose !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        pop_chk(n); pop_chk(bus.win); pop_chk(bus.move_ready); pop_chk(bus.busy);
        push("restart_lose", 0);
        do_start();
        wait_ready(n);
        pop_chk(bus.lose);

        // reset in the middle of a move
        ld = '0;
        ld[0][3] = 12'd2; ld[1][3] = 12'd8;
        do_load(ld);
        wait_ready(n);
        do_move(2'd0);
        tick();
        push("midrst_nz", 0); push("midrst_busy", 0); push("midrst_ready", 0);
        rst = 1'b1;
        #1;
        pop_chk(cnt_nz(bus.board)); pop_chk(bus.busy); pop_chk(bus.move_ready);
        tick();
        rst = 1'b0;
        tick();
        tick();
        push("post_rst_nz", 0); push("post_rst_busy", 0);
        pop_chk(cnt_nz(bus.board)); pop_chk(bus.busy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/move_ctrl.md
Name: move_ctrl

Overview:
- Sequencer for the 2048 board datapath. Owns the 4x4 tile matrix and accepts one move request at a time.
- For each move it slides and merges the four lines in turn, one line per cycle. It then spawns a new tile and checks for win or lose.
- Its board output feeds the score module and the display path.

Parameters:
- WIN_VAL, 2048, tile value that ends the game as won.
- LFSR_SEED, 16'hACE1, nonzero reset seed of the spawn LFSR.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse: begin a new game
- load  in  1  pulse: overwrite the board (verification/debug)
- load_board  in  12x4x4 [11:0][3:0][3:0]  board copied on load
- move_valid  in  1  move request
- move_dir  in  2  0=LEFT 1=RIGHT 2=UP 3=DOWN
- move_ready  out  1  high only in WAIT
- board  out  12x4x4  current tiles; board[r][c], r=0 is the top row, c=0 is the left column
- busy  out  1  high in INIT/SPAWN/MOVE/CHECK
- moved  out  1  one-cycle pulse when a move changed the board
- gain  out  13  sum of merged tile values of the last move; held until the next move
- win  out  1  sticky until start or rst
- lose  out  1  sticky until start or rst

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, board all 0, gain=0, moved=0, win=0, lose=0, LFSR=LFSR_SEED.
- States: IDLE, INIT, SPAWN_A, SPAWN_B, WAIT, MOVE, SPAWN, CHECK, DONE.
- start (any state, highest priority) -> INIT.
  - INIT: clear board, win, lose, gain.
  - Then SPAWN_A -> SPAWN_B -> CHECK -> WAIT.
- load (IDLE/WAIT/DONE only, ignored otherwise, lower priority than start) -> board=load_board, win=lose=0, -> CHECK.
- Move handshake: in WAIT, move_valid && move_ready accepts move_dir, latches it, clears the changed flag and gain, then -> MOVE.
- MOVE runs 4 cycles, line index k=0..3. Line cells are ordered toward the slide direction:
  - LEFT: row k, c=0..3
  - RIGHT: row k, c=3..0
  - UP: column k, r=0..3
  - DOWN: column k, r=3..0
- The merged line is written back the same cycle.
  - changed |= (line differs from original).
  - gain += merged values.
- After k=3:
  - changed=1 -> SPAWN (1 cycle) -> CHECK (1 cycle) -> WAIT; moved pulses in the CHECK cycle.
  - changed=0 -> WAIT directly, no spawn, moved stays 0.
- Latency from accept to move_ready: 6 cycles with a change, 4 without.
- Merge rule:
  - Compact nonzero tiles toward index 0.
  - Merge equal adjacent pairs scanning from index 0.
  - Each tile merges at most once per move: {2,2,2,2} -> {4,4,0,0}; {4,4,8,0} -> {8,8,0,0}.
  - Values are 12-bit; the game stops at WIN_VAL, so overflow is unreachable.
- Spawn:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle; start does not reseed it.
  - Start index s = lfsr[3:0]. Place a 2 in the first empty cell at linear index (s+i) mod 16, i=0..15, where linear index = r*4+c.
  - No empty cell -> no write.
- CHECK:
  - win if any cell == WIN_VAL, -> DONE.
  - Else lose if no empty cell and no horizontally or vertically adjacent equal pair, -> DONE.
  - Else -> WAIT.
  - win takes priority over lose.
- DONE: move_ready=0; only start, load or rst leave it.
- move_valid outside WAIT is ignored and not queued.
- Reset mid-MOVE: board is cleared immediately; there is no partial write-back.

Optional Feature:
- Macro SPAWN_FOUR_EN.
- Defined: a spawned tile is 4 when lfsr[7:4]==0, else 2.
- Undefined: a spawned tile is always 2.

Decomposition:
- Package game_pkg holds:
  - tile_t = logic [11:0]
  - dir_t enum (LEFT, RIGHT, UP, DOWN)
  - ctrl_state_t enum
  - WIN_VAL_DEF, LFSR_SEED_DEF
  - line_t = tile_t [3:0]
- Sub-module line_merge (combinational): in line_t; out line_t, changed, gain[12:0].
- Spawn scan and win/lose check stay inline.

Test Plan:
- Reset -> board all 0, move_ready=0, busy=0, win=lose=moved=0, gain=0.
- start -> move_ready=1 after 4 cycles; exactly two nonzero cells, each ==2 (macro off); score of board == 4.
- load row0={2,2,4,4}, rest 0; LEFT -> 4 cycles later row0={4,8,0,0}; gain=12; exactly one new 2 elsewhere; moved pulses; ready again at cycle 6.
- load row0={2,4,8,16}, rest 0; LEFT -> board unchanged, moved=0, ready after 4 cycles, gain=0; same board with RIGHT -> row0={0,...}? no: row0={2,4,8,16} also packed right -> unchanged.
- load row3={1024,1024,0,0}; LEFT -> win=1, DONE, move_ready stays 0; later move_valid is ignored; start clears win.
- load checkerboard (2/4 alternating) -> lose=1 after the CHECK cycle; assert rst during a MOVE in another run -> board 0 next sample, state IDLE.
